seg7_scan: RTL and testbench

Time-multiplexed driver for the board's 8-digit seven-segment display, the stage directly downstream of the music/status logic that produces display content. It captures a 32-bit hex value plus per-digit decimal-point and blanking masks through a single-cycle load strobe. It commits the captured values only at frame boundaries so the display never tears. It scans the digits one-hot with a programmable dwell and a dead-time gap that suppresses ghosting.

---
 rtl/seg7_scan.sv | 110 +++++++++++
 tb/tb_seg7_scan.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for an 8-digit seven-segment display with frame-aligned
// content updates and dead time between digit slots to suppress ghosting.
module seg7_scan #(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_value,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    input  logic        load,
    output logic        frame_done,
    output logic [7:0]  digit_enable,
    output logic [7:0]  segment_data
);

    localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   CNT_DEAD = CW'(DEAD_CYCLES);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    logic [31:0]   pend_value;
    logic [7:0]    pend_dp;
    logic [7:0]    pend_blank;
    logic          pend_valid;

    logic [31:0]   act_value;
    logic [7:0]    act_dp;
    logic [7:0]    act_blank;

    logic          tick;
    logic          commit;
    logic          dead;
    logic [3:0]    nibble;
    logic [6:0]    glyph;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Content swaps only on the last tick of digit 7, so a frame never mixes old and new data.
    assign tick   = (cnt == CNT_LAST);
    assign commit = tick && (idx == 3'd7) && pend_valid;
    assign dead   = (cnt < CNT_DEAD);
    assign nibble = act_value[{idx, 2'b00} +: 4];
    assign glyph  = hex_decode(nibble);

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would let commit see updated idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            idx          <= '0;
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            pend_valid   <= 1'b0;
            act_value    <= '0;
            act_dp       <= '0;
            act_blank    <= 8'hFF;
            frame_done   <= 1'b0;
            digit_enable <= '0;
            segment_data <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= idx + 3'd1;

            if (commit) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end

            // A load on the commit edge refills pending after the old contents move out.
            if (load) begin
                pend_value <= disp_value;
                pend_dp    <= dp_mask;
                pend_blank <= blank_mask;
                pend_valid <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end

            frame_done   <= commit;
            digit_enable <= dead ? 8'h00 : (8'h01 << idx);
            segment_data <= (dead || act_blank[idx]) ? 8'h00 : {act_dp[idx], glyph};
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=8, DEAD_CYCLES=2: frame-by-frame
// checks of scan pattern, decoded segments, masks, load races and reset.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] disp_value = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic        load = 1'b0;
    logic        frame_done;
    logic [7:0]  digit_enable;
    logic [7:0]  segment_data;

    int total = 0;
    int bad   = 0;

    // Up to two loads per frame: cycle index (1..64, 0 = none) and contents.
    int          ld_at    [2];
    logic [31:0] ld_val   [2];
    logic [7:0]  ld_dp    [2];
    logic [7:0]  ld_blank [2];

    seg7_scan #(.SCAN_DIV(8), .DEAD_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_value   (disp_value),
        .dp_mask      (dp_mask),
        .blank_mask   (blank_mask),
        .load         (load),
        .frame_done   (frame_done),
        .digit_enable (digit_enable),
        .segment_data (segment_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic clear_loads();
        ld_at[0] = 0;
        ld_at[1] = 0;
    endtask

    task automatic set_load(input int slot, input int at, input logic [31:0] v,
                            input logic [7:0] dp, input logic [7:0] bl);
        ld_at[slot]    = at;
        ld_val[slot]   = v;
        ld_dp[slot]    = dp;
        ld_blank[slot] = bl;
    endtask

    // Runs n cycles of a frame aligned so that cycle j=1 is the first edge of digit 0.
    // segs holds the expected segment byte for digit d in bits [8d+7:8d].
    task automatic run_frame(input string name, input logic [63:0] segs,
                             input logic fd_exp, input int n);
        for (int j = 1; j <= n; j++) begin
            int p;
            int d;
            logic [7:0] e_en;
            logic [7:0] e_seg;
            logic [7:0] e_fd;
            for (int s = 0; s < 2; s++) begin
                if (ld_at[s] == j) begin
                    disp_value = ld_val[s];
                    dp_mask    = ld_dp[s];
                    blank_mask = ld_blank[s];
                    load       = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            load  = 1'b0;
            p     = (j - 1) % 8;
            d     = (j - 1) / 8;
            e_en  = (p < 2) ? 8'h00 : (8'h01 << d);
            e_seg = (p < 2) ? 8'h00 : segs[8*d +: 8];
            e_fd  = (j == 64) ? {7'd0, fd_exp} : 8'h00;
            chk($sformatf("%s j=%0d digit_enable", name, j), digit_enable, e_en);
            chk($sformatf("%s j=%0d segment_data", name, j), segment_data, e_seg);
            chk($sformatf("%s j=%0d frame_done", name, j), {7'd0, frame_done}, e_fd);
        end
        clear_loads();
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, " digit_enable"}, digit_enable, 8'h00);
        chk({name, " segment_data"}, segment_data, 8'h00);
        chk({name, " frame_done"}, {7'd0, frame_done}, 8'h00);
    endtask

    initial begin
        clear_loads();

        // Reset held for 5 cycles with a load pulse that must be discarded.
        for (int i = 0; i < 5; i++) begin
            disp_value = 32'h76543210;
            blank_mask = 8'h00;
            load       = (i == 2);
            @(posedge clk);
            #1;
            chk_zero_outputs($sformatf("reset_hold c%0d", i));
        end
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_frame("dark_f0", 64'h0, 1'b0, 64);

        set_load(0, 20, 32'h76543210, 8'h00, 8'h00);
        run_frame("basic_load_f1", 64'h0, 1'b1, 64);
        run_frame("basic_show_f2", 64'h077D6D664F5B063F, 1'b0, 64);

        set_load(0, 5, 32'hFEDCBA98, 8'h81, 8'h02);
        run_frame("mask_load_f3", 64'h077D6D664F5B063F, 1'b1, 64);
        run_frame("mask_show_f4", 64'hF1795E397C7700FF, 1'b0, 64);

        // Two loads in one frame: the second wins.
        set_load(0, 10, 32'h11111111, 8'h00, 8'h00);
        set_load(1, 40, 32'h22222222, 8'h00, 8'h00);
        run_frame("race_ab_f5", 64'hF1795E397C7700FF, 1'b1, 64);

        // Pending 4s, then a load of 3s landing on the commit edge itself.
        set_load(0, 30, 32'h44444444, 8'h00, 8'h00);
        set_load(1, 64, 32'h33333333, 8'h00, 8'h00);
        run_frame("race_b_show_f6", 64'h5B5B5B5B5B5B5B5B, 1'b1, 64);
        run_frame("race_old_pend_f7", 64'h6666666666666666, 1'b1, 64);
        run_frame("race_c_show_f8", 64'h4F4F4F4F4F4F4F4F, 1'b0, 64);

        // Load pending, then reset asserted during digit 4.
        set_load(0, 10, 32'h55555555, 8'h00, 8'h00);
        run_frame("pre_reset_f9", 64'h4F4F4F4F4F4F4F4F, 1'b0, 34);
        rst = 1'b0;
        #1;
        chk_zero_outputs("mid_reset_immediate");
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("mid_reset_held");
        @(negedge clk);
        rst = 1'b1;

        run_frame("post_reset_r0", 64'h0, 1'b0, 64);
        run_frame("post_reset_r1", 64'h0, 1'b0, 64);
        set_load(0, 50, 32'h00000000, 8'h00, 8'h00);
        run_frame("post_reset_load", 64'h0, 1'b1, 64);
        run_frame("post_reset_show", 64'h3F3F3F3F3F3F3F3F, 1'b0, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
